// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes size/alignment, runs one memory handshake
// with a wait timeout, and formats load data for the core.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_exc,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  // state   | meaning
  // IDLE    | waiting for a core request
  // BUSY    | memory request outstanding, counting wait cycles
  // DONE    | one-cycle completion pulse, results on o_rdata/o_exc
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_MISALGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  // Last BUSY cycle index before giving up (counter starts at 0 on entry)
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;

  logic        size_legal;
  logic        misaligned;
  logic [3:0]  bmask_c;
  logic [31:0] wdata_c;
  logic [1:0]  req_exc;

  always_comb begin
    size_legal = 1'b0;
    misaligned = 1'b0;
    bmask_c    = 4'b0000;
    wdata_c    = i_wdata;
    case (i_funct3)
      3'b000: begin
        size_legal = 1'b1;
        bmask_c    = 4'b0001 << i_addr[1:0];
        wdata_c    = {4{i_wdata[7:0]}};
      end
      3'b001: begin
        size_legal = 1'b1;
        misaligned = i_addr[0];
        bmask_c    = 4'b0011 << {i_addr[1], 1'b0};
        wdata_c    = {2{i_wdata[15:0]}};
      end
      3'b010: begin
        size_legal = 1'b1;
        misaligned = |i_addr[1:0];
        bmask_c    = 4'b1111;
      end
      // Unsigned loads have no store counterpart
      3'b100: begin
        size_legal = ~i_we;
        bmask_c    = 4'b0001 << i_addr[1:0];
      end
      3'b101: begin
        size_legal = ~i_we;
        misaligned = i_addr[0];
        bmask_c    = 4'b0011 << {i_addr[1], 1'b0};
      end
      default: ;
    endcase
    if (!size_legal)
      req_exc = 2'b11;
    else if (misaligned)
      req_exc = EXC_MISALGN;
    else
      req_exc = EXC_NONE;
  end

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  always_comb begin
    case (lat_off)
      2'd0:    rd_byte = i_mem_rdata[7:0];
      2'd1:    rd_byte = i_mem_rdata[15:8];
      2'd2:    rd_byte = i_mem_rdata[23:16];
      default: rd_byte = i_mem_rdata[31:24];
    endcase
    rd_half = lat_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = i_mem_rdata;
    endcase
  end

  assign o_stall = i_reset & (((state == ST_IDLE) & i_req) | (state == ST_BUSY));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 16'd0;
      lat_we      <= 1'b0;
      lat_funct3  <= 3'd0;
      lat_off     <= 2'd0;
      o_done      <= 1'b0;
      o_rdata     <= 32'd0;
      o_exc       <= EXC_NONE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 32'd0;
      o_mem_bmask <= 4'd0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            lat_we     <= i_we;
            lat_funct3 <= i_funct3;
            lat_off    <= i_addr[1:0];
            if (req_exc != EXC_NONE) begin
              state   <= ST_DONE;
              o_done  <= 1'b1;
              o_exc   <= req_exc;
              o_rdata <= 32'd0;
            end else begin
              state       <= ST_BUSY;
              wait_cnt    <= 16'd0;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_we;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_wdata <= wdata_c;
              o_mem_bmask <= bmask_c;
            end
          end
        end
        ST_BUSY: begin
          // Ack is checked first so it wins over a same-cycle timeout
          if (i_mem_ack) begin
            state     <= ST_DONE;
            o_done    <= 1'b1;
            o_mem_req <= 1'b0;
            o_exc     <= EXC_NONE;
            o_rdata   <= lat_we ? 32'd0 : load_data;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ST_DONE;
            o_done    <= 1'b1;
            o_mem_req <= 1'b0;
            o_exc     <= EXC_TIMEOUT;
            o_rdata   <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected responses,
// a negedge monitor checks memory-side requests and completions.
module tb_lsu_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic [1:0]  o_exc;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_exc(o_exc),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  exc;
  } resp_t;

  typedef struct {
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } mem_t;

  resp_t sb_q[$];
  mem_t  mem_q[$];
  mem_t  cur_mem;
  int    n_vec = 0;
  int    n_fail = 0;
  int    req_cycles = 0;
  logic  req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: memory request contents every cycle it is high, completions on o_done
  always @(negedge i_clk) begin
    resp_t r;
    if (o_mem_req) begin
      req_cycles++;
      if (!req_prev) begin
        if (mem_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_mem_req: got addr %h, expected no request", o_mem_addr);
        end else begin
          cur_mem = mem_q.pop_front();
        end
      end
      check("mem_we", {31'd0, o_mem_we}, {31'd0, cur_mem.is_store});
      check("mem_addr", o_mem_addr, cur_mem.addr);
      if (cur_mem.is_store) begin
        check("mem_wdata", o_mem_wdata, cur_mem.wdata);
        check("mem_bmask", {28'd0, o_mem_bmask}, {28'd0, cur_mem.bmask});
      end
    end
    req_prev = o_mem_req;
    if (o_done) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_done: got o_done=1, expected 0");
      end else begin
        r = sb_q.pop_front();
        check("rdata", o_rdata, r.rdata);
        check("exc", {30'd0, o_exc}, {30'd0, r.exc});
      end
    end
  end

  // Called at a negedge with the bench idle; returns at the negedge of the done cycle.
  // ack_after = BUSY cycle index carrying the ack (0 = never ack).
  task automatic access(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_after, input logic [31:0] mrdata,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_exc,
                        input int exp_lat, input logic [3:0] exp_bmask,
                        input logic [31:0] exp_wdata);
    resp_t r;
    mem_t  m;
    bit    exp_mem;
    bit    seen;
    int    cyc;
    int    req_start;
    int    exp_req;
    exp_mem = (exp_exc == 2'b00) || (exp_exc == 2'b10);
    r.rdata = exp_rdata;
    r.exc   = exp_exc;
    sb_q.push_back(r);
    if (exp_mem) begin
      m.is_store = we;
      m.addr     = {addr[31:2], 2'b00};
      m.wdata    = exp_wdata;
      m.bmask    = exp_bmask;
      mem_q.push_back(m);
    end
    req_start = req_cycles;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    #1 check({name, "_stall_req"}, {31'd0, o_stall}, 32'd1);
    @(negedge i_clk);
    i_req = 1'b0;
    cyc = 2;
    seen = 0;
    while (!seen && cyc < 30) begin
      if (o_done) begin
        seen = 1;
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_stall_done"}, {31'd0, o_stall}, 32'd0);
      end else begin
        if (exp_mem) check({name, "_stall_busy"}, {31'd0, o_stall}, 32'd1);
        if (ack_after != 0 && cyc - 1 == ack_after) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = mrdata;
        end
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'hDEAD_BEEF;
        cyc++;
      end
    end
    if (!seen) begin
      n_vec++; n_fail++;
      $display("FAIL %s_no_done: got no o_done in %0d cycles, expected one", name, cyc);
    end
    exp_req = exp_mem ? ((ack_after == 0) ? 4 : ack_after) : 0;
    check({name, "_req_cycles"}, req_cycles - req_start, exp_req);
    @(negedge i_clk);
  endtask

  initial begin
    resp_t r;
    mem_t  m;
    i_reset = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'd0;
    i_addr = 32'd0; i_wdata = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge i_clk);
    i_req = 1'b1;
    #1;
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_exc", {30'd0, o_exc}, 32'd0);
    check("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_wdata", o_mem_wdata, 32'd0);
    check("rst_mem_bmask", {28'd0, o_mem_bmask}, 32'd0);
    @(negedge i_clk);
    i_req = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);

    //       name   we   f3      addr          wdata        ack  mem rdata      exp rdata      exc    lat bmask    exp wdata
    access("lb",   0, 3'b000, 32'h0000_1003, 32'd0,          2, 32'h80FF_1234, 32'hFFFF_FF80, 2'b00, 4, 4'b0000, 32'd0);
    @(negedge i_clk);
    check("rdata_hold", o_rdata, 32'hFFFF_FF80);
    access("sh",   1, 3'b001, 32'h0000_2002, 32'h0000_ABCD,  1, 32'h0,         32'd0,         2'b00, 3, 4'b1100, 32'hABCD_ABCD);
    access("lbu",  0, 3'b100, 32'h0000_5001, 32'd0,          1, 32'h1122_8033, 32'h0000_0080, 2'b00, 3, 4'b0000, 32'd0);
    access("lw_mis",0, 3'b010, 32'h0000_3001, 32'd0,         0, 32'h0,         32'd0,         2'b01, 2, 4'b0000, 32'd0);
    access("ill",  0, 3'b011, 32'h0000_3001, 32'd0,          0, 32'h0,         32'd0,         2'b11, 2, 4'b0000, 32'd0);
    access("tmo",  0, 3'b010, 32'h0000_3000, 32'd0,          0, 32'h0,         32'd0,         2'b10, 6, 4'b0000, 32'd0);
    access("ack4", 0, 3'b010, 32'h0000_3004, 32'd0,          4, 32'h2468_ACE0, 32'h2468_ACE0, 2'b00, 6, 4'b0000, 32'd0);
    access("lh",   0, 3'b001, 32'h0000_6002, 32'd0,          1, 32'h9ABC_1234, 32'hFFFF_9ABC, 2'b00, 3, 4'b0000, 32'd0);
    access("lhu",  0, 3'b101, 32'h0000_6000, 32'd0,          3, 32'h9ABC_F00D, 32'h0000_F00D, 2'b00, 5, 4'b0000, 32'd0);
    access("sb",   1, 3'b000, 32'h0000_7001, 32'h1234_56A5,  1, 32'h0,         32'd0,         2'b00, 3, 4'b0010, 32'hA5A5_A5A5);
    access("sw",   1, 3'b010, 32'h0000_7008, 32'hCAFE_F00D,  2, 32'h0,         32'd0,         2'b00, 4, 4'b1111, 32'hCAFE_F00D);
    access("sbu",  1, 3'b100, 32'h0000_7000, 32'h0000_0011,  0, 32'h0,         32'd0,         2'b11, 2, 4'b0000, 32'd0);
    access("sh_mis",1, 3'b001, 32'h0000_7001, 32'h0000_0011, 0, 32'h0,         32'd0,         2'b01, 2, 4'b0000, 32'd0);

    // Ack while idle must be ignored
    access("lw_a", 0, 3'b010, 32'h0000_8000, 32'd0,          1, 32'h0BAD_F00D, 32'h0BAD_F00D, 2'b00, 3, 4'b0000, 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_1111;
    repeat (2) @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("idle_ack_done", {31'd0, o_done}, 32'd0);
    check("idle_ack_req", {31'd0, o_mem_req}, 32'd0);
    check("idle_ack_rdata", o_rdata, 32'h0BAD_F00D);

    // Request held through DONE is not taken until the following IDLE cycle
    r.rdata = 32'd0; r.exc = 2'b01; sb_q.push_back(r);
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_3001;
    @(negedge i_clk);
    check("b2b_done1", {31'd0, o_done}, 32'd1);
    r.rdata = 32'd0; r.exc = 2'b11; sb_q.push_back(r);
    i_funct3 = 3'b110; i_addr = 32'h0000_3000;
    #1 check("b2b_stall_done", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    check("b2b_idle_done", {31'd0, o_done}, 32'd0);
    check("b2b_idle_stall", {31'd0, o_stall}, 32'd1);
    @(negedge i_clk);
    check("b2b_done2", {31'd0, o_done}, 32'd1);
    i_req = 1'b0;
    @(negedge i_clk);

    // Reset during the second BUSY cycle, late ack afterwards
    m.is_store = 1'b0; m.addr = 32'h0000_4000; m.wdata = 32'd0; m.bmask = 4'd0;
    mem_q.push_back(m);
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_4000;
    @(negedge i_clk);
    i_req = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0; i_req = 1'b1;
    #1 check("rstb_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    check("rstb_mem_req", {31'd0, o_mem_req}, 32'd0);
    check("rstb_done", {31'd0, o_done}, 32'd0);
    check("rstb_rdata", o_rdata, 32'd0);
    check("rstb_exc", {30'd0, o_exc}, 32'd0);
    check("rstb_mem_addr", o_mem_addr, 32'd0);
    check("rstb_mem_bmask", {28'd0, o_mem_bmask}, 32'd0);
    i_reset = 1'b1; i_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h7777_7777;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("late_ack_done", {31'd0, o_done}, 32'd0);
    check("late_ack_req", {31'd0, o_mem_req}, 32'd0);
    check("late_ack_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    check("late_ack_done2", {31'd0, o_done}, 32'd0);
    access("post_rst", 0, 3'b010, 32'h0000_4000, 32'd0, 1, 32'h1357_9BDF, 32'h1357_9BDF, 2'b00, 3, 4'b0000, 32'd0);

    repeat (3) @(negedge i_clk);
    check("sb_empty", sb_q.size(), 32'd0);
    check("mem_q_empty", mem_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1);
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles waiting for a memory acknowledge before aborting.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-low.
REQ-004 i_req  input  1  core requests a load/store this cycle.
REQ-005 i_we  input  1  1=store, 0=load.
REQ-006 i_funct3  input  3  access size/sign code from the instruction.
REQ-007 i_addr  input  32  effective byte address, taken from the ALU result.
REQ-008 i_wdata  input  32  store data from rs2.
REQ-009 o_stall  output  1  core must hold the current instruction.
REQ-010 o_done  output  1  one-cycle pulse: access complete, o_rdata/o_exc valid.
REQ-011 o_rdata  output  32  formatted load data.
REQ-012 o_exc  output  2  00 none, 01 misaligned, 10 timeout, 11 illegal size.
REQ-013 o_mem_req  output  1  memory request, held until acknowledged.
REQ-014 o_mem_we  output  1  memory write enable.
REQ-015 o_mem_addr  output  32  word address: {i_addr[31:2],2'b00}.
REQ-016 o_mem_wdata  output  32  lane-replicated store data.
REQ-017 o_mem_bmask  output  4  byte-lane enables.
REQ-018 i_mem_ack  input  1  memory accepted the write or returned the read data.
REQ-019 i_mem_rdata  input  32  read word, valid while i_mem_ack=1.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 In IDLE with i_req=1, the block SHALL latch i_we/i_funct3/i_addr/i_wdata and check the access.
REQ-022 Size decode (load): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other code is illegal.
REQ-023 Size decode (store): 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-024 An illegal size SHALL take precedence over misalignment when both apply.
REQ-025 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-026 A legal, aligned access SHALL go IDLE->BUSY and register the o_mem_* outputs.
REQ-027 An illegal or misaligned access SHALL go IDLE->DONE and issue no memory request (o_mem_req stays 0).
REQ-028 o_mem_req SHALL be 1 throughout BUSY, with all o_mem_* outputs held stable.
REQ-029 BUSY with i_mem_ack=1 SHALL go to DONE and deassert o_mem_req on that edge.
REQ-030 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-031 When the counter reaches TIMEOUT_CYCLES with no ack, the FSM SHALL go to DONE with o_exc=10.
REQ-032 If ack and timeout occur in the same cycle, the ack SHALL win: normal completion, o_exc=00.
REQ-033 DONE SHALL last exactly one cycle: o_done=1 during it, then go to IDLE.
REQ-034 i_req SHALL be ignored in DONE; a back-to-back request is accepted in the following IDLE cycle.
REQ-035 o_stall SHALL be combinational: (IDLE & i_req) | BUSY, and 0 in DONE.
REQ-036 Store byte mask: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111.
REQ-037 Store data replication: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-038 Load extraction: select the byte/half by addr[1:0] from i_mem_rdata, sign-extend for LB/LH, zero-extend for LBU/LHU.
REQ-039 Load data SHALL be registered into o_rdata on the ack edge.
REQ-040 o_rdata SHALL be 0 for stores and for any exception.
REQ-041 o_rdata and o_exc SHALL hold their values until the next access completes.
REQ-042 Minimum latency SHALL be 3 cycles, request to o_done (ack in the first BUSY cycle).
REQ-043 An error response SHALL complete in 2 cycles.
REQ-044 i_mem_ack outside BUSY SHALL be ignored.

Reset
REQ-045 With i_reset=0 at a rising edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-046 Under reset, every registered output (o_done, o_rdata, o_exc, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask) SHALL be 0.
REQ-047 Reset in BUSY SHALL drop o_mem_req on that edge; a late ack after reset SHALL be ignored.
REQ-048 o_stall SHALL be 0 during reset regardless of i_req.

Verification
REQ-049 LB at 0x1003 with memory word 0x80FF_1234, ack after 2 BUSY cycles -> o_done in cycle 4, o_rdata=0xFFFF_FF80, o_exc=00.
REQ-050 SH at 0x2002 with wdata 0x0000_ABCD -> o_mem_addr=0x2000, bmask=1100, wdata=0xABCD_ABCD, o_mem_we=1.
REQ-051 LW at 0x3001 -> o_mem_req never 1, o_done next cycle, o_exc=01, o_rdata=0.
REQ-052 Load with funct3=011 at 0x3001 -> o_exc=11 (illegal beats misaligned), no memory request.
REQ-053 TIMEOUT_CYCLES=4, no ack -> o_mem_req high 4 cycles, then o_done with o_exc=10; same test with ack on the 4th cycle -> o_exc=00.
REQ-054 Reset asserted during the 2nd BUSY cycle, ack 1 cycle later -> outputs 0, FSM in IDLE, no o_done.
